alu_sequential_exec: RTL and testbench
======================================

# alu_sequential_exec

Multi-cycle ALU execution unit that consumes the 4-bit ALU operation code generated by the ALU control decoder and performs the selected operation on two 32-bit operands. It sits between the register-file/immediate operand muxes and the writeback path. It is the consumer end of the ALU-operation interface. Shifts run iteratively, one bit per cycle, and a start/busy/done handshake lets the control path stall until the result is ready.

## Interface
- DATA_WIDTH, 32, operand/result width; shift amount taken from B_i[4:0]
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  request; accepted only when busy_o=0
- ALU_Operation_i  input  4  operation code, sampled with start_i
- A_i  input  DATA_WIDTH  operand A, sampled with start_i
- B_i  input  DATA_WIDTH  operand B / immediate, sampled with start_i
- busy_o  output  1  high while an operation is in flight (EXEC or DONE)
- done_o  output  1  one-cycle pulse: ALU_Result_o/Zero_o newly valid
- ALU_Result_o  output  DATA_WIDTH  registered result, held until next accepted start
- Zero_o  output  1  registered (ALU_Result_o == 0)

## Operation
- Op codes: 0000 ADD A+B; 0001 SUB A-B; 0011 OR A|B; 0101 LUI B<<12; 0110 SRL A>>B[4:0] (logical); any other code -> result 0.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no carry/overflow output.
- FSM states IDLE, EXEC, DONE.
  - IDLE: busy_o=0. On start_i=1: latch op, A, B into internal registers; load shift counter with B_i[4:0] for SRL, else 0; go EXEC.
  - EXEC: if op=SRL and counter!=0, shift working register right by 1 (zero fill), decrement counter, stay. Otherwise, write the final result to ALU_Result_o, update Zero_o, and go DONE.
  - DONE: done_o=1 for exactly this cycle; next edge -> IDLE unconditionally.
- Working register for SRL loads A_i at acceptance.
- start_i is ignored in EXEC and DONE (no queueing). A start asserted in DONE is not accepted; it must still be high in IDLE to be accepted.
- Operand/op inputs may change freely after acceptance without affecting the in-flight operation.
- ALU_Result_o and Zero_o change only on the EXEC->DONE edge.

## Timing
- Reset (asynchronous assert, any state): state=IDLE; busy_o=0, done_o=0, ALU_Result_o=0, Zero_o=1 (result 0); counter and working registers 0. An in-flight operation is discarded.
- Start accepted at edge N (IDLE, start_i=1): busy_o=1 from after edge N.
- Non-shift ops: EXEC for one cycle; DONE entered at edge N+1; done_o high in cycle N+1..N+2; IDLE at edge N+2.
- SRL with shamt k: k shifting edges N+1..N+k; DONE at edge N+k+1. Latency from accept to done_o = k+1 cycles; shamt 0 gives latency 1 and result = A.
- Back-to-back throughput: one accept per (latency+2) cycles minimum. The earliest next accept is the edge after DONE->IDLE.
- done_o never asserts in the same cycle as a result change that is not newly committed.

## Test plan
- Reset mid-SRL: accept SRL with A=0xFFFF_FFFF, B=20; assert reset at cycle 5 -> immediately busy_o=0, ALU_Result_o=0, Zero_o=1, no done_o pulse; after release, state is IDLE.
- ADD/SUB wrap: ADD 0xFFFF_FFFF+1 -> done_o one cycle after accept, result 0x0000_0000, Zero_o=1. SUB 5-7 -> result 0xFFFF_FFFE, Zero_o=0.
- OR and LUI: OR 0xF0F0_0000|0x0000_0F0F -> 0xF0F0_0F0F. LUI B=0x0001_2345 -> 0x1234_5000. Each has latency 1.
- SRL latency: SRL A=0x8000_0000, shamt 31 -> done_o exactly 32 cycles after accept, result 0x0000_0001. shamt 0 -> done_o after 1 cycle, result 0x8000_0000.
- Handshake: hold start_i=1 continuously with alternating ops -> accepts occur only in IDLE cycles. No accept in EXEC/DONE; every accept yields exactly one done_o pulse; ALU_Result_o stable between pulses.
- Illegal code 0111 with A=B=0x1234 -> result 0, Zero_o=1, latency 1.

Source files
------------

// File: rtl/alu_sequential_exec.sv
// rtl/alu_sequential_exec.sv - multi-cycle ALU with iterative one-bit-per-cycle logical right shift
// start/busy/done handshake; result and zero flag commit only on the EXEC->DONE edge.
module alu_sequential_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic [DATA_WIDTH-1:0] final_val;
    logic                  shifting;

    // work_q holds operand A for every op; only SRL ever modifies it
    assign shifting = (op_q == OP_SRL) && (cnt_q != 5'd0);

    always_comb begin
        final_val = '0;
        case (op_q)
            OP_ADD:  final_val = work_q + b_q;
            OP_SUB:  final_val = work_q - b_q;
            OP_OR:   final_val = work_q | b_q;
            OP_LUI:  final_val = b_q << 12;
            OP_SRL:  final_val = work_q;
            default: final_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            work_q   <= '0;
            b_q      <= '0;
            cnt_q    <= 5'd0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_EXEC;
            S_EXEC:  if (!shifting) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        work_d   = work_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d   = ALU_Operation_i;
                    work_d = A_i;
                    b_d    = B_i;
                    cnt_d  = (ALU_Operation_i == OP_SRL) ? B_i[4:0] : 5'd0;
                end
            end
            S_EXEC: begin
                if (shifting) begin
                    work_d = work_q >> 1;
                    cnt_d  = cnt_q - 5'd1;
                end else begin
                    result_d = final_val;
                    zero_d   = (final_val == '0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        ALU_Result_o = result_q;
        Zero_o       = zero_q;
    end

endmodule

// File: tb/tb_alu_sequential_exec.sv
// tb/tb_alu_sequential_exec.sv - directed self-checking bench for alu_sequential_exec
module tb_alu_sequential_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] ALU_Result_o;
    logic        Zero_o;

    int checks = 0;
    int failures = 0;

    alu_sequential_exec #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ALU_Result_o    (ALU_Result_o),
        .Zero_o          (Zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, scramble inputs after acceptance, then check latency and result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        bit seen;
        start_i = 1'b1;
        ALU_Operation_i = op;
        A_i = a;
        B_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        ALU_Operation_i = 4'b1111;
        A_i = 32'hDEAD_BEEF;
        B_i = 32'h0000_001F;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done_o) seen = 1;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, ALU_Result_o, exp_res);
        check({tag, "_zero"}, {31'd0, Zero_o}, {31'd0, exp_res == 32'd0});
        check({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int dones;
        int bad_res;
        int changed;
        logic [31:0] last_res;

        reset = 1'b0;
        start_i = 1'b0;
        ALU_Operation_i = 4'd0;
        A_i = 32'd0;
        B_i = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_res", ALU_Result_o, 32'd0);
        check("rst_zero", {31'd0, Zero_o}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("sub_neg", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run_op("or", 4'b0011, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
        run_op("lui", 4'b0101, 32'hAAAA_AAAA, 32'h0001_2345, 32'h1234_5000, 1);
        run_op("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
        run_op("srl0", 4'b0110, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
        run_op("srl4_ignores_upper_b", 4'b0110, 32'h1234_5678, 32'hFFFF_FFE4, 32'h0123_4567, 5);
        run_op("illegal", 4'b0111, 32'h1234, 32'h1234, 32'h0, 1);

        // start held high for 30 edges: accepts only from IDLE, one every 3 cycles
        run_op("pre_hs", 4'b0011, 32'h1, 32'h0, 32'h1, 1);
        last_res = 32'h1;
        dones = 0;
        bad_res = 0;
        changed = 0;
        start_i = 1'b1;
        A_i = 32'd10;
        B_i = 32'd3;
        for (int i = 0; i < 30; i++) begin
            ALU_Operation_i = i[0] ? 4'b0001 : 4'b0000;
            @(posedge clk);
            @(negedge clk);
            if (done_o) begin
                dones++;
                if (ALU_Result_o != 32'd13 && ALU_Result_o != 32'd7) bad_res++;
                last_res = ALU_Result_o;
            end else if (ALU_Result_o != last_res) begin
                changed++;
            end
        end
        start_i = 1'b0;
        check("hs_done_count", dones, 10);
        check("hs_result_values", bad_res, 0);
        check("hs_result_stable", changed, 0);
        repeat (3) @(negedge clk);
        check("hs_idle_after", {31'd0, busy_o}, 32'd0);

        // asynchronous reset in the middle of a long shift
        start_i = 1'b1;
        ALU_Operation_i = 4'b0110;
        A_i = 32'hFFFF_FFFF;
        B_i = 32'd20;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before_rst", {31'd0, busy_o}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_done", {31'd0, done_o}, 32'd0);
        check("mid_rst_res", ALU_Result_o, 32'd0);
        check("mid_rst_zero", {31'd0, Zero_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_o || busy_o) dones++;
        end
        check("mid_rst_stays_idle", dones, 0);

        run_op("post_rst_add", 4'b0000, 32'd100, 32'd23, 32'd123, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
